// File: rtl/fir_sym_tdm.sv
// Time-shared symmetric FIR: one pre-add/multiply/accumulate datapath serves every
// coefficient pair and every channel history, producing one output per M+3 cycles.
module fir_sym_tdm #(
    parameter int WIDTH    = 24,
    parameter int TAPS     = 101,
    parameter int COEF_W   = 24,
    parameter int FRAC     = 23,
    parameter int CHANNELS = 2,
    localparam int M  = (TAPS + 1) / 2,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW = (M > 1) ? $clog2(M) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CW-1:0]     in_chan,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_drop,
    output logic              chan_err,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [CW-1:0]     out_chan
);
    localparam int TW    = $clog2(TAPS);
    localparam int XW    = WIDTH + 1;
    localparam int PW    = XW + COEF_W;
    localparam int ACC_W = PW + $clog2(M);
    localparam int SH    = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic signed [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] HALF = (FRAC > 0) ? (ONE <<< SH) : '0;
    localparam logic signed [ACC_W:0] SMAX = (ONE <<< (WIDTH - 1)) - ONE;
    localparam logic signed [ACC_W:0] SMIN = -(ONE <<< (WIDTH - 1));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] t;
        t = ((ACC_W + 1)'(acc) + HALF) >>> FRAC;
        if (t > SMAX)      round_sat = SMAX[WIDTH-1:0];
        else if (t < SMIN) round_sat = SMIN[WIDTH-1:0];
        else               round_sat = t[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0]  r_hist [CHANNELS][TAPS];
    logic signed [COEF_W-1:0] r_coef [M];
    logic signed [ACC_W-1:0]  r_acc;
    logic [AW-1:0]            r_k;
    logic [CW-1:0]            r_chan;
    logic [CW-1:0]            r_out_chan;
    logic [WIDTH-1:0]         r_out_data;
    logic                     r_coef_drop;
    logic                     r_chan_err;
    state_t                   r_state;
    state_t                   w_state_nxt;

    logic                     w_accept;
    logic                     w_chan_ok;
    logic                     w_last;
    logic [TW-1:0]            w_ia;
    logic [TW-1:0]            w_ib;
    logic signed [WIDTH-1:0]  w_xa;
    logic signed [WIDTH-1:0]  w_xb;
    logic signed [COEF_W-1:0] w_h;
    logic signed [XW-1:0]     w_pre;
    logic signed [PW-1:0]     w_prod;

    assign w_accept  = in_valid && in_ready;
    assign w_chan_ok = (32'(in_chan) < CHANNELS);
    assign w_last    = (r_k == AW'(M - 1));
    assign w_ia      = TW'(r_k);
    assign w_ib      = TW'(TAPS - 1) - w_ia;
    assign w_xa      = r_hist[r_chan][w_ia];
    assign w_xb      = r_hist[r_chan][w_ib];
    assign w_h       = r_coef[r_k];
    // Centre tap has no mirror partner, so it bypasses the pre-adder.
    assign w_pre     = w_last ? XW'(w_xa) : XW'(w_xa) + XW'(w_xb);
    assign w_prod    = PW'(w_pre) * PW'(w_h);

    assign coef_drop = r_coef_drop;
    assign chan_err  = r_chan_err;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && w_chan_ok) w_state_nxt = S_MAC;
            end
            S_MAC:   if (w_last) w_state_nxt = S_ROUND;
            S_ROUND: w_state_nxt = S_OUT;
            S_OUT: begin
                out_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_chan      <= '0;
            r_coef_drop <= 1'b0;
            r_chan_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_coef_drop <= coef_we && !in_ready;
            r_chan_err  <= w_accept && !w_chan_ok;
            if (w_accept && w_chan_ok) begin
                r_k    <= '0;
                r_chan <= in_chan;
            end else if (r_state == S_MAC) begin
                r_k <= r_k + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int t = 0; t < TAPS; t++)
                    r_hist[c][t] <= '0;
            for (int k = 0; k < M; k++)
                r_coef[k] <= '0;
            r_out_data <= '0;
            r_out_chan <= '0;
        end else begin
            if (coef_we && in_ready && (32'(coef_addr) < M))
                r_coef[coef_addr] <= coef_data;
            if (w_accept && w_chan_ok) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (CW'(c) == in_chan) begin
                        r_hist[c][0] <= in_data;
                        for (int t = 1; t < TAPS; t++)
                            r_hist[c][t] <= r_hist[c][t-1];
                    end
                end
            end
            if (r_state == S_ROUND) begin
                r_out_data <= round_sat(r_acc);
                r_out_chan <= r_chan;
            end
        end
    end

    // Stage boundary: accumulator is data only; every accept restarts it from zero.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_acc <= '0;
        else if (r_state == S_MAC)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Scoreboard bench for fir_sym_tdm: a direct full-length convolution model predicts
// every output; a negedge monitor pops and compares data, channel tag and latency.
module tb_fir_sym_tdm;
    localparam int WIDTH    = 24;
    localparam int TAPS     = 101;
    localparam int COEF_W   = 24;
    localparam int FRAC     = 23;
    localparam int CHANNELS = 3;
    localparam int M        = (TAPS + 1) / 2;
    localparam int CW       = 2;
    localparam int AW       = $clog2(M);

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [CW-1:0]    ch;
        int               acyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic [CW-1:0]     in_chan = '0;
    logic              coef_we = 1'b0;
    logic [AW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              coef_drop;
    logic              chan_err;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [CW-1:0]     out_chan;

    fir_sym_tdm #(
        .WIDTH(WIDTH), .TAPS(TAPS), .COEF_W(COEF_W), .FRAC(FRAC), .CHANNELS(CHANNELS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_drop(coef_drop), .chan_err(chan_err),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               n_cmp = 0;
    int               n_bad = 0;
    exp_t             sb[$];
    logic [WIDTH-1:0] last_out = '0;
    longint           m_hist [CHANNELS][TAPS];
    longint           m_coef [M];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_y(input int ch);
        longint acc, y, lim;
        int k;
        acc = 0;
        for (int i = 0; i < TAPS; i++) begin
            k = (i < TAPS - 1 - i) ? i : TAPS - 1 - i;
            acc += m_hist[ch][i] * m_coef[k];
        end
        y   = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        lim = 64'sd1 <<< (WIDTH - 1);
        if (y > lim - 1) y = lim - 1;
        if (y < -lim)    y = -lim;
        return y[WIDTH-1:0];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CHANNELS; c++)
            for (int t = 0; t < TAPS; t++)
                m_hist[c][t] = 0;
        for (int k = 0; k < M; k++) m_coef[k] = 0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.d);
                check("out_chan", out_chan, e.ch);
                check("latency", cyc + 1 - e.acyc, M + 2);
                last_out = e.d;
            end
        end
    end

    task automatic send(input int ch, input logic [WIDTH-1:0] d, output int acyc);
        int   n;
        exp_t e;
        acyc     = -1;
        in_valid = 1'b1;
        in_chan  = CW'(ch);
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", in_ready, 1'b1);
            return;
        end
        @(posedge clk);
        #1;
        acyc = cyc;
        if (ch < CHANNELS) begin
            for (int t = TAPS - 1; t > 0; t--) m_hist[ch][t] = m_hist[ch][t-1];
            m_hist[ch][0] = longint'($signed(d));
            e.d = model_y(ch);
            e.ch = CW'(ch);
            e.acyc = acyc;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic write_coef(input int a, input logic [COEF_W-1:0] v);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = v;
        m_coef[a] = longint'($signed(v));
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, a_prev;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_coef_drop", coef_drop, 1'b0);
        check("rst_chan_err", chan_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);

        // Impulse through the outermost coefficient pair.
        write_coef(0, 24'h400000);
        send(0, 24'h100000, a);
        for (int i = 1; i < TAPS; i++) send(0, 24'h000000, a);
        drain();
        check("impulse_last", last_out, 24'h080000);
        repeat (5) @(negedge clk);
        check("out_hold", out_data, last_out);

        // Saturation in both directions.
        do_reset();
        for (int k = 0; k < M; k++) write_coef(k, 24'h7FFFFF);
        for (int i = 0; i < 4; i++) send(0, 24'h7FFFFF, a);
        drain();
        check("sat_pos", last_out, 24'h7FFFFF);
        for (int i = 0; i < 10; i++) send(0, 24'h800000, a);
        drain();
        check("sat_neg", last_out, 24'h800000);

        // Channel isolation and tagging.
        do_reset();
        write_coef(0, 24'h400000);
        for (int i = 0; i < 10; i++) begin
            send(0, (i == 0) ? 24'h100000 : 24'h000000, a);
            send(1, 24'h000000, a);
        end
        send(2, 24'h100000, a);
        drain();

        // Held valid: fixed accept spacing, random coefficients and data.
        for (int k = 0; k < M; k++) write_coef(k, COEF_W'($urandom));
        send(0, WIDTH'($urandom), a_prev);
        for (int i = 0; i < 4; i++) begin
            send(i % 3, WIDTH'($urandom), a);
            check("accept_spacing", a - a_prev, M + 3);
            a_prev = a;
        end
        drain();
        in_valid = 1'b1;
        in_chan  = 2'd3;
        in_data  = 24'h123456;
        @(negedge clk);
        in_valid = 1'b0;
        check("chan_err_pulse", chan_err, 1'b1);
        check("chan_err_stays_idle", in_ready, 1'b1);
        @(negedge clk);
        check("chan_err_clear", chan_err, 1'b0);
        repeat (60) @(negedge clk);

        // Reset in the middle of a computation.
        do_reset();
        write_coef(0, 24'h400000);
        send(0, 24'h100000, a);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (60) @(negedge clk);
        write_coef(0, 24'h400000);
        send(0, 24'h100000, a);
        drain();
        check("midrst_fresh_impulse", last_out, 24'h080000);
        for (int i = 0; i < 3; i++) send(0, 24'h000000, a);
        drain();
        check("midrst_zero_tail", last_out, 24'h000000);

        // Coefficient write while busy is dropped; in IDLE and with an accept it applies.
        do_reset();
        write_coef(0, 24'h400000);
        send(0, 24'h100000, a);
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 24'h200000;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_drop_pulse", coef_drop, 1'b1);
        @(negedge clk);
        check("coef_drop_clear", coef_drop, 1'b0);
        drain();
        check("coef_unchanged", last_out, 24'h080000);
        write_coef(0, 24'h200000);
        check("coef_idle_no_drop", coef_drop, 1'b0);
        send(1, 24'h100000, a);
        drain();
        check("coef_idle_applied", last_out, 24'h040000);
        coef_we   = 1'b1;
        coef_addr = AW'(1);
        coef_data = 24'h400000;
        m_coef[1] = 64'sh400000;
        send(1, 24'h000000, a);
        coef_we = 1'b0;
        drain();
        check("coef_with_accept", last_out, 24'h080000);

        check("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
